// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low hex glyph table
// ({dp,g,f,e,d,c,b,a}, dp off) and the position of the decimal-point bit.
package seg_pkg;

   localparam int SEG_DP_BIT = 7;

   localparam logic [7:0] SEG_HEX_TABLE [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-segment decoder producing active-low segments;
// blank_i turns segments a..g off while the decimal point is still honoured.
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   input  logic       dp_i,
   output logic [7:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_HEX_TABLE[nibble_i];
      if (blank_i) seg_n_o[6:0] = 7'h7F;
      seg_n_o[SEG_DP_BIT] = ~dp_i;
   end

endmodule

// File: rtl/seg_scan_dynamic.sv
// Multiplexed seven-segment scanner with tear-free frame commit of loaded data.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_dynamic
   import seg_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int SCAN_DIV       = 1000,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output logic [DIGITS-1:0]     sel,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int NIB_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW != 0}};
   localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW != 0}};

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              started_q;
   logic [NIB_W-1:0]  pend_data_q, pend_data_d, disp_data_q, disp_data_d;
   logic [DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic              pend_vld_q, pend_vld_d;
   logic [DIGITS-1:0] sel_q, sel_d, onehot;
   logic [7:0]        seg_q, seg_d, seg_raw;
   logic              frame_done_q;
   logic              tick, wrap;
   logic [3:0]        nibble;
   logic              nib_dp, blank;
   logic [DIGITS-1:0] blank_vec;

   // The first tick after reset shows digit 0 rather than advancing past it.
   always_comb begin
      tick        = (cnt_q == CNT_LAST);
      wrap        = tick && started_q && (idx_q == IDX_LAST);
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      if (tick) idx_d = (!started_q || idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      pend_vld_d  = pend_vld_q;
      disp_data_d = disp_data_q;
      disp_dp_d   = disp_dp_q;
      if (load) begin
         pend_data_d = data;
         pend_dp_d   = dp;
         pend_vld_d  = 1'b1;
      end
      if (wrap) begin
         pend_vld_d = 1'b0;
         if (load) begin
            disp_data_d = data;
            disp_dp_d   = dp;
         end else if (pend_vld_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
         end
      end
   end

`ifdef SEG_LZ_BLANK_EN
   always_comb begin : lz_blank
      logic zero_above;
      blank_vec  = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above   = zero_above && (disp_data_d[4*i +: 4] == 4'h0);
         blank_vec[i] = (i != 0) && zero_above;
      end
   end
`else
   assign blank_vec = '0;
`endif

   // Decode from the next-state display so a commit shows on the same update.
   always_comb begin
      nibble = disp_data_d[{idx_d, 2'b00} +: 4];
      nib_dp = disp_dp_d[idx_d];
      blank  = blank_vec[idx_d];
      onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
      sel_d  = (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg_d  = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
   end

   seg_hex_decoder u_dec (
      .nibble_i (nibble),
      .blank_i  (blank),
      .dp_i     (nib_dp),
      .seg_n_o  (seg_raw)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         started_q    <= 1'b0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_vld_q   <= 1'b0;
         disp_data_q  <= '0;
         disp_dp_q    <= '0;
         sel_q        <= SEL_OFF;
         seg_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_vld_q   <= pend_vld_d;
         disp_data_q  <= disp_data_d;
         disp_dp_q    <= disp_dp_d;
         frame_done_q <= wrap;
         if (tick) begin
            started_q <= 1'b1;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
         end
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_dynamic.md
SEG_SCAN_DYNAMIC -- requirements
Module: seg_scan_dynamic

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter SEL_ACTIVE_LOW, default 1: 1 drives an active digit select as 0.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 drives a lit segment as 0.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port data  input  4*DIGITS  hex nibble per digit; digit i is data[4i+3:4i].
REQ-008 SHALL have port dp  input  DIGITS  decimal point per digit; 1 = lit.
REQ-009 SHALL have port load  input  1  single-cycle strobe that captures data and dp.
REQ-010 SHALL have port sel  output  DIGITS  registered one-hot digit select.
REQ-011 SHALL have port seg  output  8  registered segments {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-013 SHALL run prescaler cnt over 0..SCAN_DIV-1 and assert internal tick when cnt==SCAN_DIV-1, then return cnt to 0.
REQ-014 SHALL advance digit index idx by one on each tick, wrapping from DIGITS-1 to 0, scan order 0,1,..,DIGITS-1.
REQ-015 SHALL update sel and seg for the new idx in the cycle after tick, giving exactly one registered cycle of latency.
REQ-016 SHALL keep exactly one sel bit active at all times after the first tick; sel and seg SHALL change in the same cycle.
REQ-017 SHALL assert frame_done for one cycle, coincident with the sel/seg update, when idx wraps from DIGITS-1 to 0.
REQ-018 SHALL capture data and dp into a pending register on load, with a later load overwriting an earlier uncommitted one.
REQ-019 SHALL copy pending into the display register only at a wrap tick, so a frame is never torn.
REQ-020 SHALL use the input data and dp directly as the committed value when load and a wrap tick occur in the same cycle.
REQ-021 SHALL commit nothing at a wrap tick when no load occurred since the last commit; the display register then holds its value.
REQ-022 SHALL decode hex nibbles in active-low form (before polarity) as 0..F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-023 SHALL make seg[7] the dp bit of the selected digit.
REQ-024 SHALL invert seg when SEG_ACTIVE_LOW=0 and invert sel when SEL_ACTIVE_LOW=0.

Reset
REQ-025 SHALL, while rst=1 and regardless of clk, force cnt=0, idx=0, pending and display registers to 0, frame_done=0, sel=all inactive, and seg=all segments off.
REQ-026 SHALL, when rst is asserted mid-frame, discard any pending load, and after release produce the first tick SCAN_DIV cycles later, selecting digit 0.

Configuration
REQ-027 SHALL implement leading-zero blanking under macro SEG_LZ_BLANK_EN: when defined, digit i>0 SHALL show segments a..g off if it and every higher digit hold 0, while dp is still honoured and digit 0 is never blanked; when undefined, every digit SHALL display its nibble.

Structure
REQ-028 SHALL place the 16-entry segment table and the dp bit-position constant in shared package seg_pkg.
REQ-029 SHALL implement the nibble-to-segment decode as sub-module seg_hex_decoder, which is combinational and table-driven from seg_pkg.

Verification
REQ-030 SHALL cover basic scan with DIGITS=6, SCAN_DIV=4, load data=0x123456, dp=0: after the first frame, sel steps 011111,101111,...; seg on digit 0 = B0? No -- digit 0 = nibble 6 -> 82, digit 5 = nibble 1 -> F9; each slot lasts 4 cycles.
REQ-031 SHALL cover load mid-frame: with display 0x000000, load 0xFFFFFF at idx=2 -> digits 3..5 still show C0, and all digits show 8E from the next frame onward.
REQ-032 SHALL cover load coincident with the wrap tick: load 0xAAAAAA in the same cycle as the wrap -> digit 0 of the new frame shows 88.
REQ-033 SHALL cover async reset: assert rst for 3 cycles at idx=4 between clock edges -> sel=111111 and seg=FF immediately, frame_done=0, and the first select 011111 appears after 4 cycles.
REQ-034 SHALL cover, with SEG_LZ_BLANK_EN defined, data=0x000305, dp=000100b: digits 5,4 show FF, digit 3 shows 7F, digit 2 shows B0, digit 1 shows C0, digit 0 shows 92; with the macro undefined, digits 5,4 show C0 and digit 3 shows 40.
REQ-035 SHALL cover polarity with SEL_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, nibble 8 -> the active sel bit is 1 and seg=7F.
